useq_core: RTL and testbench
============================

# useq_core

Parametrised microsequencer for the ESC64 CPU: it steps a microprogram held in an external asynchronous microcode ROM. It drives the ROM address and forwards each microword's control field to the datapath (regsel, ALU, status, RAM, IR). It adds the following over the fixed-width sequencer:
- opcode dispatch
- flag-conditional jumps
- a hardware call/return stack
- memory-ready wait states
- halt and fault states

## Interface
Parameters:
- OPCODE_WIDTH, 7, width of IR opcode
- UADDR_WIDTH, 9, microaddress width; must be >= OPCODE_WIDTH + DISPATCH_SHIFT
- CTRL_WIDTH, 21, datapath control field width
- STACK_DEPTH, 4, call-stack entries (>= 1)
- DISPATCH_SHIFT, 2, microwords reserved per opcode (2^DISPATCH_SHIFT)
- FETCH_UADDR, 0, reset microaddress
- CTRL_IDLE, all-ones, control value driven while in reset, HALT or FAULT (active-low strobes inactive)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- opcode  in  OPCODE_WIDTH  from instruction register
- flagC  in  1  status carry
- flagZ  in  1  status zero
- memReady  in  1  memory access complete
- uaddr  out  UADDR_WIDTH  microcode ROM address (= uPC register)
- uSeqOp  in  3  microword sequencing op
- uCond  in  3  microword condition select
- uTarget  in  UADDR_WIDTH  microword branch target
- uCtrl  in  CTRL_WIDTH  microword control field
- control  out  CTRL_WIDTH  datapath control
- stackLevel  out  $clog2(STACK_DEPTH+1)  occupied stack entries
- halted  out  1  HALT state
- fault  out  1  FAULT state

## Operation
- State machine: RUN, HALT, FAULT.
  - Only reset leaves HALT or FAULT.
- control = uCtrl in RUN (combinational).
- control = CTRL_IDLE in HALT, in FAULT, and while reset is low.
- Conditions (uCond):
  - 0 always
  - 1 C
  - 2 !C
  - 3 Z
  - 4 !Z
  - 5 C|Z
  - 6 !C&!Z
  - 7 never
- uSeqOp, evaluated in RUN at each rising edge:
  - 0 NEXT: uPC <= uPC+1.
  - 1 JUMP: uPC <= uTarget.
  - 2 CJUMP: uPC <= cond ? uTarget : uPC+1.
  - 3 DISPATCH: uPC <= zero-extended opcode << DISPATCH_SHIFT.
  - 4 CALL:
    - if stackLevel < STACK_DEPTH: push uPC+1, uPC <= uTarget.
    - else: state <= FAULT, uPC and stack unchanged.
  - 5 RET:
    - if stackLevel > 0: uPC <= top, pop.
    - else: state <= FAULT, uPC unchanged.
  - 6 WAITMEM:
    - memReady=1: uPC <= uPC+1.
    - memReady=0: uPC holds; uCtrl stays driven on control every wait cycle.
  - 7 HALT: state <= HALT, uPC unchanged.
- Arithmetic: uPC+1 is modulo 2^UADDR_WIDTH; the all-ones address wraps to 0, including the CALL return address.
- Stack is LIFO, implemented as a register array plus a level counter. Entries above stackLevel are don't-care.
- uCond is ignored for every op except CJUMP.
- Flags and memReady are sampled only at the clock edge.

## Timing
- Reset value (asynchronous, immediate on reset low):
  - uPC = FETCH_UADDR
  - stackLevel = 0
  - state RUN, halted = 0, fault = 0
  - control = CTRL_IDLE until reset goes high
- After reset release, the first rising edge executes the microword at FETCH_UADDR.
- Throughput: one microinstruction per clock in RUN. There are no bubbles on JUMP, CALL, RET or DISPATCH.
- Latency:
  - uaddr changes on the edge following the decision.
  - control follows uaddr through the ROM access plus a combinational path only; no register stage.
- HALT and faulting CALL/RET microwords:
  - their uCtrl is driven for their own cycle.
  - control becomes CTRL_IDLE starting from the next edge.
- halted and fault are registered and rise on the same edge as the state change.
- Reset asserted mid-operation aborts immediately, including during WAITMEM; the stack contents are lost.
- Holding memReady=1 before reaching WAITMEM gives a zero-wait pass (one cycle).

## Test plan
- Reset and sequential stepping:
  - Stimulus: reset low mid-run; ROM of NEXTs.
  - Required: uaddr=0, control=CTRL_IDLE during reset; then uaddr 0,1,2,3 on successive edges.
  - Wrap: 511 -> 0 with UADDR_WIDTH=9.
- Dispatch and conditional jump:
  - Stimulus: opcode=7'h05 with DISPATCH at 0.
  - Required: uaddr=20.
  - CJUMP cond=1, target=100: C=1 -> 100; C=0 -> 21.
  - cond=6 with C=0, Z=0 -> taken.
- Call stack:
  - Stimulus: four nested CALLs at 10, 30, 50, 70 (targets 30, 50, 70, 90), then four RETs.
  - Required: stackLevel 1..4; returns 71, 51, 31, 11.
  - A fifth CALL at depth 4 -> fault=1, control=CTRL_IDLE, uaddr frozen.
- RET underflow:
  - Stimulus: RET at stackLevel=0, at uaddr 5.
  - Required: next edge fault=1, uaddr stays 5, stackLevel stays 0.
- Memory wait:
  - Stimulus: WAITMEM at 40 with memReady low for 3 cycles, then high.
  - Required: uaddr=40 for 4 edges with control=uCtrl throughout, then 41.
  - memReady already high -> 41 after one cycle.
- Halt and recovery:
  - Stimulus: HALT at 12.
  - Required: halted=1 and control=CTRL_IDLE from the next edge; uaddr stays 12 for 10 cycles.
  - Then pulse reset -> uaddr=0, halted=0, stackLevel=0.

Source files
------------

// File: rtl/useq_core.sv
// Microsequencer for the ESC64 CPU: steps an external microcode ROM.
// Handles dispatch, conditional jumps, a call stack, memory waits and halt/fault.
module useq_core #(
  parameter int OPCODE_WIDTH   = 7,
  parameter int UADDR_WIDTH    = 9,
  parameter int CTRL_WIDTH     = 21,
  parameter int STACK_DEPTH    = 4,
  parameter int DISPATCH_SHIFT = 2,
  parameter int FETCH_UADDR    = 0,
  parameter logic [CTRL_WIDTH-1:0] CTRL_IDLE = '1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [OPCODE_WIDTH-1:0]          opcode,
  input  logic                             flagC,
  input  logic                             flagZ,
  input  logic                             memReady,
  output logic [UADDR_WIDTH-1:0]           uaddr,
  input  logic [2:0]                       uSeqOp,
  input  logic [2:0]                       uCond,
  input  logic [UADDR_WIDTH-1:0]           uTarget,
  input  logic [CTRL_WIDTH-1:0]            uCtrl,
  output logic [CTRL_WIDTH-1:0]            control,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stackLevel,
  output logic                             halted,
  output logic                             fault
);

  localparam int LW = $clog2(STACK_DEPTH + 1);
  localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    OP_NEXT,
    OP_JUMP,
    OP_CJUMP,
    OP_DISP,
    OP_CALL,
    OP_RET,
    OP_WAIT,
    OP_HALT
  } op_t;

  state_t                 state;
  op_t                    op;
  logic [UADDR_WIDTH-1:0] upc;
  logic [UADDR_WIDTH-1:0] upc_inc;
  logic [UADDR_WIDTH-1:0] disp_addr;
  logic [UADDR_WIDTH-1:0] top;
  logic [UADDR_WIDTH-1:0] stack [STACK_DEPTH];
  logic [LW-1:0]          level;
  logic [LW-1:0]          level_dec;
  logic [SW-1:0]          push_idx;
  logic [SW-1:0]          pop_idx;
  logic                   take;
  logic                   full;
  logic                   empty;
  logic                   push;

  assign op        = op_t'(uSeqOp);
  assign upc_inc   = upc + UADDR_WIDTH'(1);
  assign disp_addr = UADDR_WIDTH'(opcode) << DISPATCH_SHIFT;
  assign level_dec = level - LW'(1);
  assign full      = (level == LW'(STACK_DEPTH));
  assign empty     = (level == '0);
  assign push_idx  = level[SW-1:0];
  assign pop_idx   = level_dec[SW-1:0];
  assign top       = stack[pop_idx];
  assign push      = reset && (state == S_RUN)
                  && (op == OP_CALL) && !full;

  always_comb begin
    take = 1'b0;
    unique case (uCond)
      3'd0: take = 1'b1;
      3'd1: take = flagC;
      3'd2: take = !flagC;
      3'd3: take = flagZ;
      3'd4: take = !flagZ;
      3'd5: take = flagC | flagZ;
      3'd6: take = !flagC & !flagZ;
      3'd7: take = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_RUN;
      upc    <= UADDR_WIDTH'(FETCH_UADDR);
      level  <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else if (state == S_RUN) begin
      unique case (op)
        OP_NEXT:  upc <= upc_inc;
        OP_JUMP:  upc <= uTarget;
        OP_CJUMP: upc <= take ? uTarget : upc_inc;
        OP_DISP:  upc <= disp_addr;
        OP_CALL: begin
          if (!full) begin
            upc   <= uTarget;
            level <= level + LW'(1);
          end else begin
            state <= S_FAULT;
            fault <= 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            upc   <= top;
            level <= level_dec;
          end else begin
            state <= S_FAULT;
            fault <= 1'b1;
          end
        end
        OP_WAIT: begin
          if (memReady) upc <= upc_inc;
        end
        OP_HALT: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

  // Return-address storage needs no reset; level alone says what is valid.
  always_ff @(posedge clock) begin
    if (push) stack[push_idx] <= upc_inc;
  end

  assign uaddr      = upc;
  assign stackLevel = level;
  assign control    = (reset && state == S_RUN) ? uCtrl : CTRL_IDLE;

endmodule

// File: tb/tb_useq_core.sv
// Bench for useq_core: directed scenarios plus a random microprogram,
// all compared against a queue-based sequencing model.
module tb_useq_core;

  localparam int UW = 9;
  localparam int CW = 21;
  localparam int NW = 512;
  localparam int DEPTH = 4;

  logic          clock;
  logic          reset;
  logic [6:0]    opcode;
  logic          flagC;
  logic          flagZ;
  logic          memReady;
  logic [UW-1:0] uaddr;
  logic [2:0]    uSeqOp;
  logic [2:0]    uCond;
  logic [UW-1:0] uTarget;
  logic [CW-1:0] uCtrl;
  logic [CW-1:0] control;
  logic [2:0]    stackLevel;
  logic          halted;
  logic          fault;

  logic [2:0]    seq_rom  [NW];
  logic [2:0]    cond_rom [NW];
  logic [UW-1:0] tgt_rom  [NW];
  logic [CW-1:0] ctrl_rom [NW];

  int checks;
  int failures;

  int m_pc;
  int m_state;
  int m_stack[$];

  useq_core dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .flagC      (flagC),
    .flagZ      (flagZ),
    .memReady   (memReady),
    .uaddr      (uaddr),
    .uSeqOp     (uSeqOp),
    .uCond      (uCond),
    .uTarget    (uTarget),
    .uCtrl      (uCtrl),
    .control    (control),
    .stackLevel (stackLevel),
    .halted     (halted),
    .fault      (fault)
  );

  assign uSeqOp  = seq_rom[uaddr];
  assign uCond   = cond_rom[uaddr];
  assign uTarget = tgt_rom[uaddr];
  assign uCtrl   = ctrl_rom[uaddr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(int c);
    case (c)
      0: return 1'b1;
      1: return flagC;
      2: return !flagC;
      3: return flagZ;
      4: return !flagZ;
      5: return flagC || flagZ;
      6: return !flagC && !flagZ;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_pc = 0;
    m_state = 0;
    m_stack.delete();
  endfunction

  // States: 0 running, 1 halted, 2 faulted.
  function automatic void model_step();
    int op;
    int inc;
    int tgt;
    if (m_state != 0) return;
    op  = int'(seq_rom[m_pc]);
    tgt = int'(tgt_rom[m_pc]);
    inc = (m_pc + 1) % NW;
    case (op)
      0: m_pc = inc;
      1: m_pc = tgt;
      2: m_pc = cond_ok(int'(cond_rom[m_pc])) ? tgt : inc;
      3: m_pc = (int'(opcode) * 4) % NW;
      4: begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(inc);
          m_pc = tgt;
        end else m_state = 2;
      end
      5: begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_state = 2;
      end
      6: if (memReady) m_pc = inc;
      default: m_state = 1;
    endcase
  endfunction

  task automatic check_all(string tag);
    logic [CW-1:0] ec;
    ec = (!reset || m_state != 0) ? '1 : ctrl_rom[m_pc];
    chk({tag, ".uaddr"}, 32'(uaddr), 32'(m_pc));
    chk({tag, ".control"}, 32'(control), 32'(ec));
    chk({tag, ".level"}, 32'(stackLevel), 32'(m_stack.size()));
    chk({tag, ".halted"}, 32'(halted), 32'(m_state == 1));
    chk({tag, ".fault"}, 32'(fault), 32'(m_state == 2));
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_all("rel");
  endtask

  task automatic rom_fill();
    for (int i = 0; i < NW; i++) begin
      seq_rom[i]  = 3'd0;
      cond_rom[i] = 3'($urandom);
      tgt_rom[i]  = UW'($urandom);
      ctrl_rom[i] = CW'($urandom) & 21'h1FFFFE;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    opcode = 7'h00;
    flagC = 1'b0;
    flagZ = 1'b0;
    memReady = 1'b0;
    model_reset();

    // Sequential stepping and reset
    rom_fill();
    do_reset();
    tick("seq");
    chk("seq1", 32'(uaddr), 1);
    tick("seq");
    chk("seq2", 32'(uaddr), 2);
    tick("seq");
    chk("seq3", 32'(uaddr), 3);
    tick("seq");
    do_reset();
    chk("midrst", 32'(uaddr), 0);

    // Wrap of NEXT and of CALL return address
    seq_rom[0] = 3'd1;
    tgt_rom[0] = 9'd510;
    do_reset();
    tick("wrap");
    tick("wrap");
    tick("wrap");
    chk("wrap_next", 32'(uaddr), 0);
    seq_rom[511] = 3'd4;
    tgt_rom[511] = 9'd200;
    seq_rom[200] = 3'd5;
    do_reset();
    for (int i = 0; i < 4; i++) tick("wcall");
    chk("wrap_ret", 32'(uaddr), 0);

    // Dispatch and conditional jumps
    rom_fill();
    seq_rom[0] = 3'd3;
    seq_rom[20] = 3'd2;
    cond_rom[20] = 3'd1;
    tgt_rom[20] = 9'd100;
    seq_rom[21] = 3'd2;
    cond_rom[21] = 3'd6;
    tgt_rom[21] = 9'd200;
    opcode = 7'h05;
    do_reset();
    tick("disp");
    chk("disp", 32'(uaddr), 20);
    flagC = 1'b1;
    tick("cj_t");
    chk("cj_taken", 32'(uaddr), 100);
    do_reset();
    flagC = 1'b0;
    tick("disp");
    tick("cj_n");
    chk("cj_not", 32'(uaddr), 21);
    flagZ = 1'b0;
    tick("cj6");
    chk("cj_c6", 32'(uaddr), 200);

    // Nested calls and returns, then overflow
    rom_fill();
    seq_rom[0] = 3'd1;
    tgt_rom[0] = 9'd10;
    seq_rom[10] = 3'd4; tgt_rom[10] = 9'd30;
    seq_rom[30] = 3'd4; tgt_rom[30] = 9'd50;
    seq_rom[50] = 3'd4; tgt_rom[50] = 9'd70;
    seq_rom[70] = 3'd4; tgt_rom[70] = 9'd90;
    seq_rom[90] = 3'd5;
    seq_rom[71] = 3'd5;
    seq_rom[51] = 3'd5;
    seq_rom[31] = 3'd5;
    do_reset();
    tick("call");
    for (int i = 0; i < 4; i++) begin
      tick("call");
      chk("call_lvl", 32'(stackLevel), 32'(i + 1));
    end
    tick("ret");
    chk("ret1", 32'(uaddr), 71);
    tick("ret");
    chk("ret2", 32'(uaddr), 51);
    tick("ret");
    chk("ret3", 32'(uaddr), 31);
    tick("ret");
    chk("ret4", 32'(uaddr), 11);
    seq_rom[90] = 3'd4;
    tgt_rom[90] = 9'd300;
    do_reset();
    for (int i = 0; i < 5; i++) tick("ovf");
    tick("ovf");
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_idle", 32'(control), 32'h1FFFFF);
    chk("ovf_addr", 32'(uaddr), 90);
    tick("ovf_hold");
    tick("ovf_hold");

    // Return underflow
    rom_fill();
    seq_rom[0] = 3'd1;
    tgt_rom[0] = 9'd5;
    seq_rom[5] = 3'd5;
    do_reset();
    tick("unf");
    tick("unf");
    chk("unf_fault", 32'(fault), 1);
    chk("unf_addr", 32'(uaddr), 5);
    chk("unf_lvl", 32'(stackLevel), 0);

    // Memory wait states
    rom_fill();
    seq_rom[0] = 3'd1;
    tgt_rom[0] = 9'd40;
    seq_rom[40] = 3'd6;
    memReady = 1'b0;
    do_reset();
    tick("wait");
    for (int i = 0; i < 3; i++) begin
      tick("wait");
      chk("wait_hold", 32'(uaddr), 40);
    end
    memReady = 1'b1;
    tick("wait");
    chk("wait_done", 32'(uaddr), 41);
    do_reset();
    tick("zw");
    tick("zw");
    chk("zero_wait", 32'(uaddr), 41);

    // Halt and recovery
    rom_fill();
    seq_rom[0] = 3'd1;
    tgt_rom[0] = 9'd12;
    seq_rom[12] = 3'd7;
    do_reset();
    tick("halt");
    tick("halt");
    chk("halted", 32'(halted), 1);
    chk("halt_idle", 32'(control), 32'h1FFFFF);
    for (int i = 0; i < 10; i++) begin
      tick("halt_hold");
      chk("halt_addr", 32'(uaddr), 12);
    end
    do_reset();
    chk("rec_addr", 32'(uaddr), 0);
    chk("rec_halt", 32'(halted), 0);
    chk("rec_lvl", 32'(stackLevel), 0);

    // Random microprogram with random flags and memory readiness
    for (int i = 0; i < NW; i++) begin
      seq_rom[i]  = ($urandom_range(0, 99) < 2) ? 3'd7
                  : 3'($urandom_range(0, 6));
      cond_rom[i] = 3'($urandom);
      tgt_rom[i]  = UW'($urandom);
      ctrl_rom[i] = CW'($urandom) & 21'h1FFFFE;
    end
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      flagC = 1'($urandom);
      flagZ = 1'($urandom);
      memReady = 1'($urandom);
      opcode = 7'($urandom);
      if ((m_state != 0 && $urandom_range(0, 7) == 0)
          || $urandom_range(0, 199) == 0)
        do_reset();
      else
        tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
